dm_arbiter: RTL and testbench

Shares the single-port, byte-addressed data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port). It selects one requester per cycle using round-robin priority, and lets DBG lock the memory for short bursts with a bounded hold time. It rejects misaligned or out-of-range accesses before they reach the memory. It sits between the MEM stage / debug module and the data memory, and drives the memory's DMWr, DMType, addr and din.

---
 rtl/dm_arbiter_if.sv | 47 ++++
 rtl/dm_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dm_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Bundle of the CPU, debug and data-memory signals around the data-memory arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and memory.
interface dm_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [2:0]  cpu_type;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        cpu_err;

   logic        dbg_valid;
   logic        dbg_ready;
   logic        dbg_lock;
   logic        dbg_we;
   logic [2:0]  dbg_type;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_wdata;
   logic [31:0] dbg_rdata;
   logic        dbg_rvalid;
   logic        dbg_err;

   logic        mem_wr;
   logic [2:0]  mem_type;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall, cpu_err,
      input  dbg_valid, dbg_lock, dbg_we, dbg_type, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_rdata, dbg_rvalid, dbg_err,
      output mem_wr, mem_type, mem_addr, mem_din,
      input  mem_dout
   );

   modport master (
      output cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall, cpu_err,
      output dbg_valid, dbg_lock, dbg_we, dbg_type, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_rdata, dbg_rvalid, dbg_err,
      input  mem_wr, mem_type, mem_addr, mem_din,
      output mem_dout
   );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter between the MEM stage and the debug port for the single-port data memory,
// with bounded debug lock bursts and alignment / range fault rejection.
module dm_arbiter #(
   parameter int DM_BYTES = 1024,
   parameter int MAX_LOCK = 8
) (
   input logic         clk,
   input logic         rst,
   dm_arbiter_if.slave bus
);
   localparam logic [2:0] DM_WORD     = 3'd0;
   localparam logic [2:0] DM_HALF     = 3'd1;
   localparam logic [2:0] DM_HALF_U   = 3'd2;
   localparam logic [2:0] DM_BYTE     = 3'd3;
   localparam logic [2:0] DM_BYTE_U   = 3'd4;
   localparam logic [7:0]  MAX_CNT    = 8'(MAX_LOCK);
   localparam logic [32:0] LAST_BYTE  = 33'(DM_BYTES - 1);

   typedef enum logic [1:0] {ARB, LOCK, FORCE} state_t;
   typedef enum logic {CPU = 1'b0, DBG = 1'b1} side_t;

   state_t      state;
   side_t       rr_ptr;
   logic [7:0]  lock_cnt;
   logic [7:0]  cnt_inc;

   logic        arb_cpu, arb_dbg;
   logic        gnt_cpu, gnt_dbg;
   logic        sel_we;
   logic [2:0]  sel_type;
   logic [31:0] sel_addr, sel_wdata;
   logic [2:0]  size;
   logic        misaligned;
   logic [32:0] end_addr;
   logic        fault;
   logic        dbg_rd_ok;

   assign cnt_inc = (lock_cnt >= MAX_CNT) ? MAX_CNT : lock_cnt + 8'd1;

   // Plain round-robin decision, reused by ARB and by the cycle that leaves LOCK.
   always_comb begin
      arb_cpu = 1'b0;
      arb_dbg = 1'b0;
      if (bus.cpu_req && bus.dbg_valid) begin
         arb_cpu = (rr_ptr == CPU);
         arb_dbg = (rr_ptr == DBG);
      end else begin
         arb_cpu = bus.cpu_req;
         arb_dbg = bus.dbg_valid;
      end
   end

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      gnt_cpu = 1'b0;
      gnt_dbg = 1'b0;
      if (!rst) begin
         unique case (state)
            LOCK: begin
               if (bus.dbg_lock && bus.dbg_valid) begin
                  gnt_dbg = 1'b1;
               end else begin
                  gnt_cpu = arb_cpu;
                  gnt_dbg = arb_dbg;
               end
            end
            FORCE: begin
               gnt_cpu = bus.cpu_req;
               gnt_dbg = !bus.cpu_req && bus.dbg_valid;
            end
            default: begin
               gnt_cpu = arb_cpu;
               gnt_dbg = arb_dbg;
            end
         endcase
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_type  = 3'd0;
      sel_addr  = 32'd0;
      sel_wdata = 32'd0;
      if (gnt_dbg) begin
         sel_we    = bus.dbg_we;
         sel_type  = bus.dbg_type;
         sel_addr  = bus.dbg_addr;
         sel_wdata = bus.dbg_wdata;
      end else if (gnt_cpu) begin
         sel_we    = bus.cpu_we;
         sel_type  = bus.cpu_type;
         sel_addr  = bus.cpu_addr;
         sel_wdata = bus.cpu_wdata;
      end
   end

   always_comb begin
      size       = 3'd1;
      misaligned = 1'b0;
      unique case (sel_type)
         DM_WORD: begin
            size       = 3'd4;
            misaligned = (sel_addr[1:0] != 2'b00);
         end
         DM_HALF, DM_HALF_U: begin
            size       = 3'd2;
            misaligned = sel_addr[0];
         end
         DM_BYTE, DM_BYTE_U: size = 3'd1;
         default:            size = 3'd1;
      endcase
   end

   // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range.
   assign end_addr  = {1'b0, sel_addr} + {30'd0, size} - 33'd1;
   assign fault     = (gnt_cpu || gnt_dbg) && (misaligned || (end_addr > LAST_BYTE));
   assign dbg_rd_ok = gnt_dbg && !sel_we && !fault;

   assign bus.mem_wr    = (gnt_cpu || gnt_dbg) && sel_we && !fault;
   assign bus.mem_type  = sel_type;
   assign bus.mem_addr  = sel_addr;
   assign bus.mem_din   = sel_wdata;
   assign bus.cpu_rdata = bus.mem_dout;
   assign bus.cpu_stall = bus.cpu_req && !gnt_cpu;
   assign bus.cpu_err   = gnt_cpu && fault;
   assign bus.dbg_ready = gnt_dbg;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ARB;
         rr_ptr         <= CPU;
         lock_cnt       <= 8'd0;
         bus.dbg_rdata  <= 32'd0;
         bus.dbg_rvalid <= 1'b0;
         bus.dbg_err    <= 1'b0;
      end else begin
         bus.dbg_rvalid <= dbg_rd_ok;
         bus.dbg_err    <= gnt_dbg && fault;
         if (dbg_rd_ok) bus.dbg_rdata <= bus.mem_dout;

         unique case (state)
            ARB: begin
               if (arb_cpu) rr_ptr <= DBG;
               if (arb_dbg) rr_ptr <= CPU;
               if (arb_dbg && bus.dbg_lock) begin
                  state    <= LOCK;
                  lock_cnt <= 8'd1;
               end
            end
            LOCK: begin
               if (bus.dbg_lock && bus.dbg_valid) begin
                  lock_cnt <= cnt_inc;
                  if (cnt_inc == MAX_CNT && bus.cpu_req) state <= FORCE;
               end else begin
                  state    <= ARB;
                  rr_ptr   <= CPU;
                  lock_cnt <= 8'd0;
               end
            end
            FORCE: begin
               state    <= ARB;
               rr_ptr   <= DBG;
               lock_cnt <= 8'd0;
            end
            default: state <= ARB;
         endcase
      end
   end
endmodule

// File: tb/tb_dm_arbiter.sv
// Table-driven bench for dm_arbiter with a byte-addressed memory model and a scoreboard
// for the registered debug responses.
module tb_dm_arbiter;
   localparam logic [2:0] W  = 3'd0;
   localparam logic [2:0] H  = 3'd1;
   localparam logic [2:0] HU = 3'd2;
   localparam logic [2:0] B  = 3'd3;
   localparam logic [2:0] BU = 3'd4;

   logic clk = 1'b0;
   logic rst;
   dm_arbiter_if bus ();

   dm_arbiter #(.DM_BYTES(1024), .MAX_LOCK(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Little-endian byte memory with combinational read.
   bit [7:0] m [1024];
   logic [9:0] a0, a1, a2, a3;
   always_comb begin
      a0 = bus.mem_addr[9:0];
      a1 = a0 + 10'd1;
      a2 = a0 + 10'd2;
      a3 = a0 + 10'd3;
      case (bus.mem_type)
         H:       bus.mem_dout = {{16{m[a1][7]}}, m[a1], m[a0]};
         HU:      bus.mem_dout = {16'd0, m[a1], m[a0]};
         B:       bus.mem_dout = {{24{m[a0][7]}}, m[a0]};
         BU:      bus.mem_dout = {24'd0, m[a0]};
         default: bus.mem_dout = {m[a3], m[a2], m[a1], m[a0]};
      endcase
   end

   always @(posedge clk) begin
      if (bus.mem_wr) begin
         m[a0] <= bus.mem_din[7:0];
         if (bus.mem_type == W || bus.mem_type == H || bus.mem_type == HU) m[a1] <= bus.mem_din[15:8];
         if (bus.mem_type == W) begin
            m[a2] <= bus.mem_din[23:16];
            m[a3] <= bus.mem_din[31:24];
         end
      end
   end

   typedef struct packed {
      logic        req, we;
      logic [2:0]  typ;
      logic [31:0] addr, wdata;
   } cpu_t;
   typedef struct packed {
      logic        valid, lock, we;
      logic [2:0]  typ;
      logic [31:0] addr, wdata;
   } dbg_t;
   typedef struct packed {
      logic        stall, ready, wr, cerr, chk_rd;
      logic [31:0] crd;
      logic        rv, err;
      logic [31:0] rd;
   } exp_t;
   typedef struct packed {
      logic rst;
      cpu_t c;
      dbg_t d;
      exp_t x;
   } vec_t;
   typedef struct {
      string       tag;
      logic        rv, err;
      logic [31:0] rd;
   } resp_t;

   int          total = 0;
   int          bad   = 0;
   resp_t       sb [$];
   logic [31:0] held_rd = 32'd0;
   vec_t        vt [$];

   function automatic cpu_t cld(input logic [2:0] t, input logic [31:0] a);
      cpu_t c;
      c.req = 1'b1; c.we = 1'b0; c.typ = t; c.addr = a; c.wdata = 32'd0;
      return c;
   endfunction
   function automatic cpu_t cst(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
      cpu_t c;
      c.req = 1'b1; c.we = 1'b1; c.typ = t; c.addr = a; c.wdata = d;
      return c;
   endfunction
   function automatic dbg_t dld(input logic l, input logic [2:0] t, input logic [31:0] a);
      dbg_t d;
      d.valid = 1'b1; d.lock = l; d.we = 1'b0; d.typ = t; d.addr = a; d.wdata = 32'd0;
      return d;
   endfunction
   function automatic dbg_t dst(input logic l, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] v);
      dbg_t d;
      d.valid = 1'b1; d.lock = l; d.we = 1'b1; d.typ = t; d.addr = a; d.wdata = v;
      return d;
   endfunction
   function automatic exp_t ex(input logic st, input logic rdy, input logic wr, input logic ce,
                               input logic chk, input logic [31:0] crd, input logic rv,
                               input logic er, input logic [31:0] rd);
      exp_t x;
      x.stall = st; x.ready = rdy; x.wr = wr; x.cerr = ce; x.chk_rd = chk; x.crd = crd;
      x.rv = rv; x.err = er; x.rd = rd;
      return x;
   endfunction
   function automatic vec_t mkv(input logic r, input cpu_t c, input dbg_t d, input exp_t x);
      vec_t v;
      v.rst = r; v.c = c; v.d = d; v.x = x;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic pop_resp();
      resp_t r;
      if (sb.size() > 0) begin
         r = sb.pop_front();
         check({r.tag, "/dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(r.rv));
         check({r.tag, "/dbg_err"},    32'(bus.dbg_err),    32'(r.err));
         check({r.tag, "/dbg_rdata"},  bus.dbg_rdata,       r.rd);
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      pop_resp();
      rst           = v.rst;
      bus.cpu_req   = v.c.req;
      bus.cpu_we    = v.c.we;
      bus.cpu_type  = v.c.typ;
      bus.cpu_addr  = v.c.addr;
      bus.cpu_wdata = v.c.wdata;
      bus.dbg_valid = v.d.valid;
      bus.dbg_lock  = v.d.lock;
      bus.dbg_we    = v.d.we;
      bus.dbg_type  = v.d.typ;
      bus.dbg_addr  = v.d.addr;
      bus.dbg_wdata = v.d.wdata;
      #1;
      check({tag, "/cpu_stall"}, 32'(bus.cpu_stall), 32'(v.x.stall));
      check({tag, "/dbg_ready"}, 32'(bus.dbg_ready), 32'(v.x.ready));
      check({tag, "/mem_wr"},    32'(bus.mem_wr),    32'(v.x.wr));
      check({tag, "/cpu_err"},   32'(bus.cpu_err),   32'(v.x.cerr));
      if (v.x.chk_rd) check({tag, "/cpu_rdata"}, bus.cpu_rdata, v.x.crd);
      if (v.rst)       held_rd = 32'd0;
      else if (v.x.rv) held_rd = v.x.rd;
      sb.push_back('{tag, v.x.rv, v.x.err, held_rd});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      cpu_t c0;
      dbg_t d0;
      exp_t x0;
      logic [31:0] dbf;
      c0 = '0; d0 = '0; x0 = '0;
      dbf = 32'hDEADBEEF;
      rst = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_type = 3'd0;
      bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
      bus.dbg_valid = 1'b0; bus.dbg_lock = 1'b0; bus.dbg_we = 1'b0; bus.dbg_type = 3'd0;
      bus.dbg_addr = 32'd0; bus.dbg_wdata = 32'd0;

      // Reset, requests during reset ignored, basic CPU store/load.
      vt.push_back(mkv(1, cst(W, 32'h20, 32'h11111111), d0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0)));
      vt.push_back(mkv(1, c0, d0, x0));
      vt.push_back(mkv(0, cst(W, 32'h10, dbf), d0, ex(0, 0, 1, 0, 0, 0, 0, 0, 0)));
      vt.push_back(mkv(0, cld(W, 32'h10), d0, ex(0, 0, 0, 0, 1, dbf, 0, 0, 0)));
      vt.push_back(mkv(0, cld(W, 32'h20), d0, ex(0, 0, 0, 0, 1, 32'h0, 0, 0, 0)));
      // Round-robin alternation starting from CPU after reset.
      vt.push_back(mkv(1, c0, d0, x0));
      for (int i = 0; i < 2; i++) begin
         vt.push_back(mkv(0, cld(W, 32'h10), dld(0, W, 32'h10), ex(0, 0, 0, 0, 1, dbf, 0, 0, 0)));
         vt.push_back(mkv(0, cld(W, 32'h10), dld(0, W, 32'h10), ex(1, 1, 0, 0, 0, 0, 1, 0, dbf)));
      end
      // Lock burst: 8 DBG beats, one FORCE cycle for the CPU, then DBG wins ARB.
      vt.push_back(mkv(0, cld(W, 32'h10), d0, ex(0, 0, 0, 0, 1, dbf, 0, 0, 0)));
      for (int i = 0; i < 8; i++)
         vt.push_back(mkv(0, cld(W, 32'h10), dld(1, W, 32'h10), ex(1, 1, 0, 0, 0, 0, 1, 0, dbf)));
      vt.push_back(mkv(0, cld(W, 32'h10), dld(1, W, 32'h10), ex(0, 0, 0, 0, 1, dbf, 0, 0, 0)));
      vt.push_back(mkv(0, cld(W, 32'h10), dld(1, W, 32'h10), ex(1, 1, 0, 0, 0, 0, 1, 0, dbf)));
      vt.push_back(mkv(0, cld(W, 32'h10), d0, ex(0, 0, 0, 0, 1, dbf, 0, 0, 0)));
      // Faults: misaligned CPU store, DBG halfword past the end, memory untouched.
      vt.push_back(mkv(0, cst(W, 32'h12, 32'h12345678), d0, ex(0, 0, 0, 1, 0, 0, 0, 0, 0)));
      vt.push_back(mkv(0, c0, dld(0, H, 32'h3FF), ex(0, 1, 0, 0, 0, 0, 0, 1, 0)));
      vt.push_back(mkv(0, cld(W, 32'h10), d0, ex(0, 0, 0, 0, 1, dbf, 0, 0, 0)));
      vt.push_back(mkv(0, cld(W, 32'h14), d0, ex(0, 0, 0, 0, 1, 32'h0, 0, 0, 0)));
      // Last-byte write and reads at the top of memory.
      vt.push_back(mkv(0, c0, dst(0, B, 32'h3FF, 32'hA5), ex(0, 1, 1, 0, 0, 0, 0, 0, 0)));
      vt.push_back(mkv(0, c0, dld(0, BU, 32'h3FF), ex(0, 1, 0, 0, 0, 0, 1, 0, 32'hA5)));
      vt.push_back(mkv(0, cld(W, 32'h3FC), d0, ex(0, 0, 0, 0, 1, 32'hA5000000, 0, 0, 0)));
      vt.push_back(mkv(0, cld(B, 32'h3FF), d0, ex(0, 0, 0, 0, 1, 32'hFFFFFFA5, 0, 0, 0)));
      vt.push_back(mkv(0, cld(H, 32'h3FE), d0, ex(0, 0, 0, 0, 1, 32'hFFFFA500, 0, 0, 0)));
      vt.push_back(mkv(0, cld(W, 32'h3FD), d0, ex(0, 0, 0, 1, 0, 0, 0, 0, 0)));
      vt.push_back(mkv(0, cld(HU, 32'h400), d0, ex(0, 0, 0, 1, 0, 0, 0, 0, 0)));
      vt.push_back(mkv(0, cld(B, 32'hFFFFFFFF), d0, ex(0, 0, 0, 1, 0, 0, 0, 0, 0)));
      vt.push_back(mkv(0, c0, dst(0, W, 32'h400, 32'h5A5A5A5A), ex(0, 1, 0, 0, 0, 0, 0, 1, 0)));
      // Reset in the middle of a lock burst with a read presented.
      vt.push_back(mkv(1, c0, d0, x0));
      for (int i = 0; i < 3; i++)
         vt.push_back(mkv(0, c0, dld(1, W, 32'h10), ex(0, 1, 0, 0, 0, 0, 1, 0, dbf)));
      vt.push_back(mkv(1, cld(W, 32'h10), dld(1, W, 32'h10), ex(1, 0, 0, 0, 0, 0, 0, 0, 0)));
      vt.push_back(mkv(0, cld(W, 32'h10), d0, ex(0, 0, 0, 0, 1, dbf, 0, 0, 0)));

      for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("v%0d", i));

      // Lock counter saturates while the CPU is idle, then FORCE once the CPU asks.
      step(mkv(1, c0, d0, x0), "sat_rst");
      for (int i = 0; i < 10; i++)
         step(mkv(0, c0, dld(1, W, 32'h10), ex(0, 1, 0, 0, 0, 0, 1, 0, dbf)), $sformatf("sat_beat%0d", i));
      step(mkv(0, cld(W, 32'h3FC), dld(1, W, 32'h10), ex(1, 1, 0, 0, 0, 0, 1, 0, dbf)), "sat_cpu_arrives");
      step(mkv(0, cld(W, 32'h3FC), dld(1, W, 32'h10), ex(0, 0, 0, 0, 1, 32'hA5000000, 0, 0, 0)), "sat_force");
      step(mkv(0, cld(W, 32'h3FC), dld(1, W, 32'h10), ex(1, 1, 0, 0, 0, 0, 1, 0, dbf)), "sat_dbg_next");
      step(mkv(0, c0, d0, x0), "sat_idle");
      @(negedge clk);
      pop_resp();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
